// File: rtl/gpu_mem_disagg_pkg.sv
`default_nettype none
// ============================================================================
// Package : gpu_mem_disagg_pkg
// Purpose : Shared definitions for the streaming GPU memory disaggregator.
//           Holds the reference configuration and the constants derived from
//           it (elements per word, elements per beat, output beats per full
//           beat), the FSM state type and the word-count clamp helper.
// Revision: 1.0 - initial streaming release
// ============================================================================
package gpu_mem_disagg_pkg;

  // Reference configuration; the top-level parameter defaults derive from it
  localparam int DEF_IN_LANES  = 8;
  localparam int DEF_WORD_W    = 16;
  localparam int DEF_ELEM_W    = 8;
  localparam int DEF_OUT_LANES = 4;

  localparam int K         = DEF_WORD_W / DEF_ELEM_W;
  localparam int TOTAL     = DEF_IN_LANES * K;
  localparam int MAX_BEATS = TOTAL / DEF_OUT_LANES;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // A word count of zero or beyond the lane count means "all lanes valid"
  function automatic int clamp_words(input int words, input int max_words);
    return ((words == 0) || (words > max_words)) ? max_words : words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpu_mem_elem_splitter.sv
`default_nettype none
// ============================================================================
// Module  : gpu_mem_elem_splitter
// Purpose : Combinational split of one packed word into WORD_W/ELEM_W
//           elements, each zero-extended to WORD_W bits.
// Ports   : word  - packed input word
//           elems - element j at [j*WORD_W +: WORD_W]
// Revision: 1.0 - initial streaming release
// ============================================================================
module gpu_mem_elem_splitter #(
  parameter int WORD_W     = 16,
  parameter int ELEM_W     = 8,
  parameter int ELEM_ORDER = 0
) (
  input  logic [WORD_W-1:0]                   word,
  output logic [(WORD_W/ELEM_W)*WORD_W-1:0]   elems
);

  localparam int KE = WORD_W / ELEM_W;

  for (genvar j = 0; j < KE; j++) begin : g_elem
    // Order 0 emits the most-significant slice as element 0
    localparam int SRC = (ELEM_ORDER == 0) ? (KE - 1 - j) : j;
    assign elems[j*WORD_W +: WORD_W] = WORD_W'(word[SRC*ELEM_W +: ELEM_W]);
  end

endmodule
`default_nettype wire

// File: rtl/gpu_mem_disaggregator_stream.sv
`default_nettype none
// ============================================================================
// Module  : gpu_mem_disaggregator_stream
// Purpose : Accepts one beat of IN_LANES packed words per handshake, splits
//           every word into zero-extended elements and re-serialises them
//           over OUT_LANES lanes across several output beats with keep and
//           last tagging.
// Ports   : clock, reset (async, active-low)
//           io_in_*  - input beat: valid/ready, payload, word count, last
//           io_out_* - output beat: valid/ready, data, keep, last
// Revision: 1.0 - initial streaming release
// ============================================================================
module gpu_mem_disaggregator_stream
  import gpu_mem_disagg_pkg::*;
#(
  parameter int IN_LANES   = TOTAL / K,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int ELEM_W     = DEF_WORD_W / K,
  parameter int OUT_LANES  = TOTAL / MAX_BEATS,
  parameter int ELEM_ORDER = 0
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           io_in_valid,
  output logic                           io_in_ready,
  input  logic [IN_LANES*WORD_W-1:0]     io_in_payload,
  input  logic [$clog2(IN_LANES+1)-1:0]  io_in_words,
  input  logic                           io_in_last,
  output logic                           io_out_valid,
  input  logic                           io_out_ready,
  output logic [OUT_LANES*WORD_W-1:0]    io_out_data,
  output logic [OUT_LANES-1:0]           io_out_keep,
  output logic                           io_out_last
);

  localparam int KE        = WORD_W / ELEM_W;
  localparam int TOTAL_E   = IN_LANES * KE;
  localparam int BEATS_MAX = TOTAL_E / OUT_LANES;
  localparam int N_W       = $clog2(TOTAL_E + 1);
  localparam int CNT_W     = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;

  // Split every input word; element e = w*KE + j lands at [e*WORD_W +: WORD_W]
  logic [TOTAL_E*WORD_W-1:0] split_elems;

  for (genvar w = 0; w < IN_LANES; w++) begin : g_split
    gpu_mem_elem_splitter #(
      .WORD_W     (WORD_W),
      .ELEM_W     (ELEM_W),
      .ELEM_ORDER (ELEM_ORDER)
    ) u_split (
      .word  (io_in_payload[w*WORD_W +: WORD_W]),
      .elems (split_elems[w*KE*WORD_W +: KE*WORD_W])
    );
  end

  // Element count and index of the final output beat for the offered beat
  int               words_in;
  logic [N_W-1:0]   n_in;
  logic [CNT_W-1:0] last_beat_in;

  always_comb begin
    words_in     = clamp_words(int'(io_in_words), IN_LANES);
    n_in         = N_W'(words_in * KE);
    last_beat_in = CNT_W'((words_in * KE + OUT_LANES - 1) / OUT_LANES - 1);
  end

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          last_beat;
  logic [N_W-1:0]            n_held;
  logic                      last_held;
  logic [TOTAL_E*WORD_W-1:0] hold;
  logic                      out_valid_r;

  logic final_beat;
  logic in_fire;

  assign final_beat = (state == DRAIN) && (cnt == last_beat);
  // A new beat may enter only once the final output beat is leaving, which
  // makes ready depend combinationally on the consumer's ready.
  assign io_in_ready = reset && ((state == IDLE) || (final_beat && io_out_ready));
  assign in_fire     = io_in_valid && io_in_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last_beat   <= '0;
      n_held      <= '0;
      last_held   <= 1'b0;
      hold        <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            state       <= DRAIN;
            out_valid_r <= 1'b1;
            cnt         <= '0;
            hold        <= split_elems;
            n_held      <= n_in;
            last_beat   <= last_beat_in;
            last_held   <= io_in_last;
          end
        end
        DRAIN: begin
          if (io_out_ready) begin
            if (cnt != last_beat) begin
              cnt <= cnt + 1'b1;
            end else if (in_fire) begin
              // Final beat leaves while the next beat enters: no bubble
              cnt       <= '0;
              hold      <= split_elems;
              n_held    <= n_in;
              last_beat <= last_beat_in;
              last_held <= io_in_last;
            end else begin
              state       <= IDLE;
              out_valid_r <= 1'b0;
              cnt         <= '0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Output lane mux; only registered state feeds it, so the beat stays
  // stable while the consumer stalls.
  always_comb begin
    int idx;
    idx         = 0;
    io_out_data = '0;
    io_out_keep = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      idx = int'(cnt) * OUT_LANES + i;
      if (out_valid_r && (idx < int'(n_held))) begin
        io_out_keep[i]                  = 1'b1;
        io_out_data[i*WORD_W +: WORD_W] = hold[idx*WORD_W +: WORD_W];
      end
    end
  end

  assign io_out_valid = out_valid_r;
  assign io_out_last  = out_valid_r && (cnt == last_beat) && last_held;

endmodule
`default_nettype wire
